// File: rtl/spraid_pkg.sv
// Shared types for the SPI flash scheduler: FSM encoding, byte width and latched byte request.
package spraid_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_HOLD,
    ST_RELEASE
  } sched_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } byte_req_t;
endpackage

// File: rtl/spraid_rr_arb.sv
// Round-robin pick: one-hot grant for the first set req bit at or after ptr, wrapping.
module spraid_rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);
  logic found;
  int   j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spraid_spi_sched.sv
// Shares one SPI byte engine among NREQ requesters; an owner keeps CS low across a burst.
// Define SPRAID_SCHED_TIMEOUT_EN to release CS when the owner idles HOLD_TIMEOUT cycles in HOLD.
module spraid_spi_sched
  import spraid_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int GUARD        = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*BYTE_W-1:0] wdata,
  output logic [NREQ-1:0]        ack,
  output logic [BYTE_W-1:0]      rdata,
  output logic [NREQ-1:0]        owner,
  output logic                   eng_start,
  output logic [BYTE_W-1:0]      eng_tx,
  input  logic                   eng_done,
  input  logic [BYTE_W-1:0]      eng_rx,
  output logic                   spi_csb,
  output logic                   timeout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  sched_state_e      state, state_n;
  logic [NREQ-1:0]   owner_n, ack_n, grant;
  logic [PW-1:0]     own_idx, own_idx_n, rr_ptr, rr_ptr_n, gidx;
  byte_req_t         cur, cur_n;
  logic [BYTE_W-1:0] rdata_n;
  logic              eng_start_n, csb_n;
  logic [GW-1:0]     gcnt, gcnt_n;
`ifdef SPRAID_SCHED_TIMEOUT_EN
  localparam int HCW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  logic [HCW-1:0]    hcnt, hcnt_n;
  logic              timeout_q, timeout_n;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign eng_tx = cur.data;

  spraid_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) gidx = PW'(i);
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    own_idx_n   = own_idx;
    rr_ptr_n    = rr_ptr;
    cur_n       = cur;
    ack_n       = '0;
    rdata_n     = rdata;
    eng_start_n = 1'b0;
    csb_n       = spi_csb;
    gcnt_n      = gcnt;
`ifdef SPRAID_SCHED_TIMEOUT_EN
    hcnt_n      = hcnt;
    timeout_n   = 1'b0;
`endif
    case (state)
      ST_IDLE: if (|req) begin
        owner_n   = grant;
        own_idx_n = gidx;
        cur_n     = '{last: last[gidx], data: wdata[int'(gidx)*BYTE_W +: BYTE_W]};
        csb_n     = 1'b0;
        state_n   = ST_SEND;
      end
      ST_SEND: begin
        eng_start_n = 1'b1;
        state_n     = ST_WAIT;
      end
      ST_WAIT: if (eng_done) begin
        ack_n   = owner;
        rdata_n = eng_rx;
        gcnt_n  = '0;
`ifdef SPRAID_SCHED_TIMEOUT_EN
        hcnt_n  = '0;
`endif
        if (cur.last) begin
          csb_n   = 1'b1;
          state_n = ST_RELEASE;
        end else begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // req is still the previous byte's while ack is out; only a fresh request counts
        if (req[own_idx] && ack == '0) begin
          cur_n   = '{last: last[own_idx], data: wdata[int'(own_idx)*BYTE_W +: BYTE_W]};
          state_n = ST_SEND;
        end
`ifdef SPRAID_SCHED_TIMEOUT_EN
        else if (hcnt == HCW'(HOLD_TIMEOUT)) begin
          timeout_n = 1'b1;
          csb_n     = 1'b1;
          gcnt_n    = '0;
          state_n   = ST_RELEASE;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        if (gcnt == GW'(GUARD - 1)) begin
          owner_n  = '0;
          rr_ptr_n = (own_idx == PW'(NREQ - 1)) ? '0 : own_idx + 1'b1;
          state_n  = ST_IDLE;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      owner     <= '0;
      own_idx   <= '0;
      rr_ptr    <= '0;
      cur       <= '0;
      ack       <= '0;
      rdata     <= '0;
      eng_start <= 1'b0;
      spi_csb   <= 1'b1;
      gcnt      <= '0;
`ifdef SPRAID_SCHED_TIMEOUT_EN
      hcnt      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      own_idx   <= own_idx_n;
      rr_ptr    <= rr_ptr_n;
      cur       <= cur_n;
      ack       <= ack_n;
      rdata     <= rdata_n;
      eng_start <= eng_start_n;
      spi_csb   <= csb_n;
      gcnt      <= gcnt_n;
`ifdef SPRAID_SCHED_TIMEOUT_EN
      hcnt      <= hcnt_n;
      timeout_q <= timeout_n;
`endif
    end
  end
endmodule

// File: tb/tb_spraid_spi_sched.sv
// Directed bench for spraid_spi_sched: single-byte vector table plus burst, arbitration, hold and reset sequences.
module tb_spraid_spi_sched;
  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [1:0]  req = '0, last = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  ack, owner;
  logic [7:0]  rdata, eng_tx;
  logic        eng_start, spi_csb, timeout;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_rx = '0;

  int total = 0;
  int bad   = 0;

  spraid_spi_sched #(.NREQ(2), .GUARD(2), .HOLD_TIMEOUT(255)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .req       (req),
    .last      (last),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .owner     (owner),
    .eng_start (eng_start),
    .eng_tx    (eng_tx),
    .eng_done  (eng_done),
    .eng_rx    (eng_rx),
    .spi_csb   (spi_csb),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end want end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         who;
    logic [7:0] tx;
    logic [7:0] rx;
    int         dly;
    logic [1:0] exp_owner;
    logic [7:0] exp_tx;
    logic [7:0] exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // engine completes dly cycles after the cycle in which the caller stands
  task automatic do_done(input logic [7:0] rx, input int dly);
    repeat (dly - 1) tick();
    eng_done = 1'b1;
    eng_rx   = rx;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic run_single(input vec_t v);
    req[v.who]            = 1'b1;
    last[v.who]           = 1'b1;
    wdata[v.who*8 +: 8]   = v.tx;
    tick();
    chk("grant_owner", owner, v.exp_owner);
    chk("grant_csb", spi_csb, 0);
    chk("no_early_start", eng_start, 0);
    tick();
    chk("start_lat2", eng_start, 1);
    chk("eng_tx", eng_tx, v.exp_tx);
    tick();
    chk("start_1cyc", eng_start, 0);
    do_done(v.rx, v.dly - 1);
    chk("ack", ack, v.exp_owner);
    chk("rdata", rdata, v.exp_rdata);
    chk("csb_release", spi_csb, 1);
    req  = '0;
    last = '0;
    tick();
    chk("ack_pulse", ack, 0);
    chk("guard_csb", spi_csb, 1);
    chk("guard_owner", owner, v.exp_owner);
    tick();
    chk("idle_owner", owner, 0);
    chk("idle_rdata_hold", rdata, v.exp_rdata);
  endtask

  vec_t vecs[5];
  logic [7:0] bb[4];
  int n, errs;

  initial begin
    vecs[0] = '{0, 8'h03, 8'hA5, 8, 2'b01, 8'h03, 8'hA5};
    vecs[1] = '{1, 8'h5A, 8'h3C, 2, 2'b10, 8'h5A, 8'h3C};
    vecs[2] = '{0, 8'hFF, 8'h00, 5, 2'b01, 8'hFF, 8'h00};
    vecs[3] = '{1, 8'h00, 8'hFF, 3, 2'b10, 8'h00, 8'hFF};
    vecs[4] = '{1, 8'h81, 8'h7E, 4, 2'b10, 8'h81, 8'h7E};
    bb[0] = 8'h0B; bb[1] = 8'h00; bb[2] = 8'h10; bb[3] = 8'h00;

    // reset state
    tick(); tick();
    chk("rst_csb", spi_csb, 1);
    chk("rst_start", eng_start, 0);
    chk("rst_tx", eng_tx, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout, 0);
    resetb = 1'b1;
    tick();

    // engine completion outside WAIT is ignored
    eng_done = 1'b1; eng_rx = 8'h5E;
    tick();
    eng_done = 1'b0;
    chk("idle_done_ack", ack, 0);
    chk("idle_done_rdata", rdata, 0);
    chk("idle_done_csb", spi_csb, 1);

    foreach (vecs[i]) run_single(vecs[i]);

    // simultaneous requests after reset: 0 first, then 1
    resetb = 1'b0; tick(); resetb = 1'b1; tick();
    req = 2'b11; last = 2'b11; wdata = {8'h22, 8'h11};
    tick();
    chk("sim_owner0", owner, 2'b01);
    tick();
    chk("sim_start0", eng_start, 1);
    chk("sim_tx0", eng_tx, 8'h11);
    do_done(8'h99, 4);
    chk("sim_ack0", ack, 2'b01);
    chk("sim_rdata0", rdata, 8'h99);
    req[0] = 1'b0;
    tick(); tick();
    chk("sim_owner_idle", owner, 2'b00);
    tick();
    chk("sim_owner1", owner, 2'b10);
    tick();
    chk("sim_start1", eng_start, 1);
    chk("sim_tx1", eng_tx, 8'h22);
    do_done(8'h44, 2);
    chk("sim_ack1", ack, 2'b10);
    chk("sim_rdata1", rdata, 8'h44);
    req = '0;
    tick(); tick(); tick();

    // burst lock: requester 0 keeps CS across 4 bytes while requester 1 waits
    req = 2'b11; last = 2'b10; wdata = {8'hEE, bb[0]};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("burst_send_owner", owner, 2'b01);
      chk("burst_no_start", eng_start, 0);
      tick();
      chk("burst_start", eng_start, 1);
      chk("burst_tx", eng_tx, bb[k]);
      chk("burst_csb", spi_csb, 0);
      do_done(8'h50 + 8'(k), 3);
      chk("burst_ack", ack, 2'b01);
      chk("burst_rdata", rdata, 8'h50 + 8'(k));
      chk("burst_csb_after", spi_csb, (k < 3) ? 1'b0 : 1'b1);
      tick();
      chk("burst_ack_pulse", ack, 0);
      chk("burst_hold_owner", owner, 2'b01);
      if (k < 3) begin
        wdata[7:0] = bb[k+1];
        last[0]    = (k + 1 == 3);
      end else begin
        req[0] = 1'b0;
      end
    end
    tick();
    chk("burst_idle_owner", owner, 2'b00);
    tick();
    chk("burst_then_owner1", owner, 2'b10);
    tick();
    chk("burst_r1_tx", eng_tx, 8'hEE);
    do_done(8'h66, 2);
    chk("burst_r1_ack", ack, 2'b10);
    req = '0; last = '0;
    tick(); tick(); tick();

    // owner goes quiet after a non-last byte
    req[0] = 1'b1; last[0] = 1'b0; wdata[7:0] = 8'h42;
    tick(); tick();
    chk("hold_start", eng_start, 1);
    do_done(8'h24, 3);
    chk("hold_ack", ack, 2'b01);
    chk("hold_csb", spi_csb, 0);
    tick();
    req[0] = 1'b0;
`ifdef SPRAID_SCHED_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 400) begin
      tick();
      n++;
    end
    chk("to_latency", n, 255);
    chk("to_csb", spi_csb, 1);
    tick();
    chk("to_pulse", timeout, 0);
    tick();
    chk("to_owner", owner, 0);
`else
    errs = 0;
    repeat (300) begin
      tick();
      if (timeout || spi_csb) errs++;
    end
    chk("hold_forever", errs, 0);
    chk("hold_owner", owner, 2'b01);
    req[0] = 1'b1; last[0] = 1'b1; wdata[7:0] = 8'h43;
    tick(); tick();
    chk("hold_resume_start", eng_start, 1);
    chk("hold_resume_tx", eng_tx, 8'h43);
    do_done(8'h34, 2);
    chk("hold_resume_ack", ack, 2'b01);
    chk("hold_resume_csb", spi_csb, 1);
    req = '0; last = '0;
    tick(); tick();
`endif

    // reset while waiting on the engine
    req[0] = 1'b1; last[0] = 1'b1; wdata[7:0] = 8'h77;
    tick(); tick();
    chk("rw_start", eng_start, 1);
    tick(); tick();
    chk("rw_csb_low", spi_csb, 0);
    #2 resetb = 1'b0;
    #1;
    chk("rw_async_csb", spi_csb, 1);
    chk("rw_async_owner", owner, 0);
    req = '0; last = '0;
    repeat (3) begin
      tick();
      chk("rw_no_ack", ack, 0);
    end
    resetb = 1'b1;
    eng_done = 1'b1; eng_rx = 8'hDD;
    tick();
    eng_done = 1'b0;
    chk("rw_late_ack", ack, 0);
    chk("rw_late_rdata", rdata, 0);
    chk("rw_late_owner", owner, 0);
    chk("rw_late_csb", spi_csb, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spraid_spi_sched.md
SPRAID_SPI_SCHED -- requirements
Module: spraid_spi_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters sharing the SPI byte engine.
REQ-002 SHALL have parameter GUARD, default 2: minimum cycles spi_csb stays high between transactions.
REQ-003 SHALL have parameter HOLD_TIMEOUT, default 255: maximum idle cycles with CS low while owner is between bytes.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port resetb, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req, input, NREQ: per-requester byte request, held high until matching ack.
REQ-007 SHALL have port last, input, NREQ: marks the requested byte as the final byte of the transaction.
REQ-008 SHALL have port wdata, input, NREQ*8: per-requester TX byte, requester i at bits [8i+7:8i].
REQ-009 SHALL have port ack, output, NREQ: one-cycle pulse to the owner when its byte completes.
REQ-010 SHALL have port rdata, output, 8: RX byte of the last completed transfer, valid from the ack cycle until the next ack.
REQ-011 SHALL have port owner, output, NREQ: one-hot current owner, all zero when idle.
REQ-012 SHALL have port eng_start, output, 1: one-cycle start pulse to the SPI byte engine.
REQ-013 SHALL have port eng_tx, output, 8: byte for the engine, stable from eng_start until eng_done.
REQ-014 SHALL have port eng_done, input, 1: engine completion pulse.
REQ-015 SHALL have port eng_rx, input, 8: engine RX byte, valid with eng_done.
REQ-016 SHALL have port spi_csb, output, 1: flash chip select, active low.
REQ-017 SHALL have port timeout, output, 1: one-cycle pulse when a hold timeout forces release.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, WAIT, HOLD, RELEASE.
REQ-019 IDLE: when any req is high, SHALL select the winner round-robin from pointer rr_ptr, set owner, latch wdata and last, drive spi_csb low, and go to SEND on the next edge.
REQ-020 SEND: SHALL assert eng_start for exactly one cycle with eng_tx set to the latched byte, then go to WAIT.
REQ-021 WAIT: on eng_done, SHALL pulse ack[owner], register eng_rx into rdata, and go to RELEASE if the latched last is set, otherwise to HOLD.
REQ-022 HOLD: while req[owner] is high, SHALL latch wdata and last and go to SEND; spi_csb stays low and other requesters are ignored.
REQ-023 HOLD: SHALL count idle cycles; at count == HOLD_TIMEOUT it SHALL pulse timeout and go to RELEASE.
REQ-024 RELEASE: SHALL drive spi_csb high for GUARD cycles, set rr_ptr to owner+1 modulo NREQ, clear owner, then go to IDLE.
REQ-025 Latency from req high in IDLE to eng_start high SHALL be exactly 2 cycles; request-to-request latency in HOLD SHALL be 2 cycles.
REQ-026 If the owner's req drops in WAIT, the transfer SHALL complete normally and ack SHALL still pulse.
REQ-027 If several reqs rise in the same cycle, exactly one SHALL be granted: the first set bit at or after rr_ptr, wrapping from NREQ-1 to 0.
REQ-028 eng_done outside WAIT SHALL be ignored.

Reset
REQ-029 While resetb is low: state SHALL be IDLE, spi_csb 1, eng_start 0, eng_tx 0, ack 0, rdata 0, owner 0, timeout 0, rr_ptr 0, and all counters 0.
REQ-030 Reset asserted mid-transaction SHALL abort immediately with spi_csb high and no ack.

Configuration
REQ-031 With SPRAID_SCHED_TIMEOUT_EN defined, the hold timeout of REQ-023 SHALL be active.
REQ-032 Without SPRAID_SCHED_TIMEOUT_EN, HOLD SHALL wait indefinitely, timeout SHALL be tied to 0, and the hold counter SHALL be omitted.

Structure
REQ-033 The state encoding and byte width constant (8) SHALL live in the shared package spraid_pkg.
REQ-034 Round-robin selection SHALL be a sub-module spraid_rr_arb that takes req and rr_ptr and returns a one-hot grant.

Verification
REQ-035 Single byte: req[0]=1, last[0]=1, wdata=0x03, engine done after 8 cycles with eng_rx=0xA5 -> eng_start 2 cycles after req, ack[0] pulse, rdata=0xA5, spi_csb high for 2 cycles.
REQ-036 Simultaneous: req=2'b11 after reset -> requester 0 served first, then requester 1; owner sequence 01, 00, 10.
REQ-037 Burst lock: requester 0 sends 4 bytes (0x0B,0x00,0x10,0x00) with last on the fourth while req[1] is held high -> spi_csb stays low across all 4 bytes, no grant to requester 1 until RELEASE completes.
REQ-038 Timeout (macro defined, HOLD_TIMEOUT=255): owner drops req after a non-last byte -> timeout pulses once 255 cycles later and spi_csb rises.
REQ-039 Reset in WAIT: resetb low 3 cycles mid-byte -> spi_csb=1 and owner=0 asynchronously, no ack, a late eng_done is ignored.
